// File: rtl/s27.sv
// s27: ISCAS-89 s27 sequential benchmark, three flip-flops with a Mealy output G17.
module s27 (
    input  logic CK,
    input  logic RN,
    input  logic G0,
    input  logic G1,
    input  logic G2,
    input  logic G3,
    output logic G17
);
    logic g5, g6, g7;
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    always_comb begin
        g14 = ~G0;
        g8  = g14 & g6;
        g12 = ~(G1 | g7);
        g15 = g12 | g8;
        g16 = G3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(G2 | g12);
        G17 = ~g11;
    end
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            g5 <= 1'b0;
            g6 <= 1'b0;
            g7 <= 1'b0;
        end else begin
            g5 <= g10;
            g6 <= g11;
            g7 <= g13;
        end
    end
endmodule

// File: tb/tb_s27.sv
// tb_s27: directed and randomized checks of s27 against a reference model.
module tb_s27;
    logic CK = 1'b0;
    logic RN = 1'b0;
    logic G0 = 1'b0, G1 = 1'b0, G2 = 1'b0, G3 = 1'b0;
    logic G17;
    int total = 0;
    int bad = 0;
    logic [2:0] ms;

    s27 dut (.CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3), .G17(G17));

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [2:0] s, input logic [3:0] g);
        logic n0, a8, o12, n11;
        n0  = !g[0];
        a8  = n0 && s[1];
        o12 = !(g[1] || s[0]);
        n11 = !(s[2] || !((g[3] || a8) && (o12 || a8)));
        // {G17, next g5, next g6, next g7}
        return {!n11, !(n0 || n11), n11, !(g[2] || o12)};
    endfunction

    function automatic logic [2:0] st();
        return {dut.g5, dut.g6, dut.g7};
    endfunction

    task automatic set_in(input logic [3:0] g);
        {G3, G2, G1, G0} = g;
    endtask

    task automatic reset_pulse();
        @(negedge CK);
        set_in(4'b0000);
        RN = 1'b0;
        #1;
        RN = 1'b1;
        ms = 3'b000;
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] m;
        #2;
        chk("rst_g17", {3'b0, G17}, 4'b0001);
        chk("rst_state", {1'b0, st()}, 4'b0000);
        @(negedge CK);
        RN = 1'b1;
        repeat (3) @(posedge CK);
        #1;
        chk("rel_state", {1'b0, st()}, 4'b0000);
        chk("rel_g17", {3'b0, G17}, 4'b0001);

        reset_pulse();
        set_in(4'b1000);
        #1;
        chk("g3_comb", {3'b0, G17}, 4'b0000);
        @(posedge CK); #1;
        chk("g3_state", {1'b0, st()}, 4'b0010);
        chk("g3_g17", {3'b0, G17}, 4'b0000);

        reset_pulse();
        set_in(4'b0010);
        @(posedge CK); #1;
        chk("g1_state", {1'b0, st()}, 4'b0001);
        @(negedge CK);
        set_in(4'b1000);
        #1;
        chk("g1_g3_g17", {3'b0, G17}, 4'b0001);
        RN = 1'b0;
        #1;
        chk("midrst_state", {1'b0, st()}, 4'b0000);
        chk("midrst_g17", {3'b0, G17}, 4'b0000);
        RN = 1'b1;

        reset_pulse();
        set_in(4'b0001);
        #1;
        chk("g0_comb", {3'b0, G17}, 4'b0001);
        @(posedge CK); #1;
        chk("g0_state", {1'b0, st()}, 4'b0100);
        chk("g0_g17", {3'b0, G17}, 4'b0001);

        reset_pulse();
        for (int i = 0; i < 1000; i++) begin
            @(negedge CK);
            g = 4'($urandom_range(0, 15));
            set_in(g);
            #1;
            m = model(ms, g);
            chk("rnd_g17", {3'b0, G17}, {3'b0, m[3]});
            @(posedge CK);
            ms = m[2:0];
            #1;
            chk("rnd_state", {1'b0, st()}, {1'b0, ms});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/s27.md
S27 -- requirements
Module: s27

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 CK  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 RN  input  1  reset, asynchronous, active-low; clears all state while low.
REQ-004 G0  input  1  primary input 0.
REQ-005 G1  input  1  primary input 1.
REQ-006 G2  input  1  primary input 2.
REQ-007 G3  input  1  primary input 3.
REQ-008 G17  output  1  primary output, combinational (Mealy) function of inputs and state.

Function
REQ-009 The block SHALL contain exactly three state flip-flops: G5, G6, G7.
REQ-010 The block SHALL implement this combinational network, evaluated continuously:
- G14 = NOT G0
- G8 = G14 AND G6
- G12 = NOR(G1, G7)
- G15 = G12 OR G8
- G16 = G3 OR G8
- G9 = NAND(G16, G15)
- G11 = NOR(G5, G9)
- G10 = NOR(G14, G11)
- G13 = NOR(G2, G12)
- G17 = NOT G11
REQ-011 At each CK rising edge with RN high, the block SHALL load G5 <= G10, G6 <= G11, G7 <= G13.
REQ-012 G17 SHALL respond to input changes in the same cycle, with no clock latency (combinational path from G0..G3 to G17).
REQ-013 State changes SHALL affect G17 only after the capturing CK rising edge (one-cycle latency through the flip-flops).
REQ-014 The block SHALL have no handshake, enable or valid signals; all inputs are sampled on every rising edge.
REQ-015 No combinational loop SHALL exist; every feedback path SHALL pass through G5, G6 or G7.
REQ-016 Inputs changing between clock edges SHALL NOT alter state until the next rising edge.
REQ-017 The implementation SHALL be gate-equivalent to REQ-010/011; any logic minimisation that preserves the input/state-to-output and next-state functions is allowed.

Reset
REQ-018 While RN is low, G5, G6 and G7 SHALL be 0 immediately, independent of CK.
REQ-019 With state 000 and G0..G3 = 0000, G17 SHALL be 1, and next state SHALL be 000.
REQ-020 Deassertion of RN SHALL take effect asynchronously; the first state update SHALL occur on the first CK rising edge with RN high.
REQ-021 Reset asserted mid-operation SHALL clear the state at once, and G17 SHALL immediately reflect the zero-state function of the current inputs.
REQ-022 No output or state SHALL be X after reset, for any known input values.

Verification
REQ-023 RN low, inputs 0000 -> G17 = 1; after RN release and 3 edges, state = 000 and G17 = 1.
REQ-024 From reset state, G3 = 1 (others 0) -> G17 = 0 combinationally; after one edge, state (G5,G6,G7) = 010 and G17 stays 0.
REQ-025 From reset state, G1 = 1 for one edge -> state = 001. Then G1 = 0 and G3 = 1 -> G17 = 1, versus 0 in REQ-024 (state dependence check).
REQ-026 From reset state, G0 = 1 (others 0) -> G17 = 1; after one edge, state = 100 and G17 remains 1.
REQ-027 After reaching state 001 as in REQ-025, assert RN low mid-cycle with G3 = 1 -> state = 000 immediately and G17 = 0 without any clock edge.
REQ-028 Random inputs applied mid-period for at least 1000 cycles -> G17 and state SHALL match a cycle-accurate reference model of REQ-010/011 at every edge.
